// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered NOT/NAND/ADD/MUL ALU with valid/ready handshakes
// MUL runs one shift-add partial product per cycle; the other ops finish on the accept edge.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Y,
  output logic               zero,
  output logic               carry
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
  logic [2*WIDTH-2:0]   r_acc, w_acc_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0]   r_y, w_y_nxt;
  logic                 r_zero, r_carry;
  logic                 w_carry_nxt, w_y_load;
  logic [WIDTH:0]       w_add, w_psum;
  logic [2*WIDTH-1:0]   w_prod;

  // r_acc holds bits [2W-1:1] of the accumulator; bit 0 would only ever hold a shifted-out zero.
  assign w_add  = {1'b0, A} + {1'b0, B};
  assign w_psum = {1'b0, r_acc[2*WIDTH-2:WIDTH-1]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_prod = {w_psum, r_acc[WIDTH-2:0]};

  always_comb begin
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_y_nxt      = r_y;
    w_carry_nxt  = 1'b0;
    w_y_load     = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_DONE;
          w_y_load    = 1'b1;
          unique case (sel)
            2'b00: w_y_nxt = {A, ~A};
            2'b01: w_y_nxt = {{WIDTH{1'b0}}, ~(A & B)};
            2'b10: begin
              w_y_nxt     = {{(WIDTH-1){1'b0}}, w_add};
              w_carry_nxt = w_add[WIDTH];
            end
            default: begin
              w_y_load     = 1'b0;
              w_mcand_nxt  = A;
              w_mplier_nxt = B;
              w_acc_nxt    = '0;
              w_cnt_nxt    = CW'(WIDTH);
              w_state_nxt  = S_MUL;
            end
          endcase
        end
      end
      S_MUL: begin
        w_acc_nxt    = w_prod[2*WIDTH-1:1];
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_y_nxt     = w_prod;
          w_y_load    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_y      <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      if (w_y_load) begin
        r_y     <= w_y_nxt;
        r_zero  <= (w_y_nxt == '0);
        r_carry <= w_carry_nxt;
      end
    end
  end

  assign Y     = r_y;
  assign zero  = r_zero;
  assign carry = r_carry;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed and swept checks of seq_alu at WIDTH 4, 8 and 2
// Drives and samples on the falling edge; the DUTs act on the rising edge.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic       iv4, ir4, ov4, or4, z4, c4;
  logic [3:0] a4, b4;
  logic [1:0] s4;
  logic [7:0] y4;

  logic        iv8, ir8, ov8, or8, z8, c8;
  logic [7:0]  a8, b8;
  logic [1:0]  s8;
  logic [15:0] y8;

  logic       iv2, ir2, ov2, or2, z2, c2;
  logic [1:0] a2, b2;
  logic [1:0] s2;
  logic [3:0] y2;

  seq_alu #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4), .sel(s4),
    .out_valid(ov4), .out_ready(or4), .Y(y4), .zero(z4), .carry(c4)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .sel(s8),
    .out_valid(ov8), .out_ready(or8), .Y(y8), .zero(z8), .carry(c8)
  );

  seq_alu #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2), .sel(s2),
    .out_valid(ov2), .out_ready(or2), .Y(y2), .zero(z2), .carry(c2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_y(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] s);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case (s)
      2'd0:    return (a << w) | (~a & m);
      2'd1:    return ~(a & b) & m;
      2'd2:    return a + b;
      default: return a * b;
    endcase
  endfunction

  function automatic logic ref_c(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] s);
    logic [63:0] t;
    t = a + b;
    return (s == 2'd2) && t[w];
  endfunction

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    @(negedge clk);
    iv4 = 1'b1; a4 = a; b4 = b; s4 = s;
    @(negedge clk);
    iv4 = 1'b0; a4 = ~a; b4 = ~b; s4 = ~s;
  endtask

  task automatic expect4(input string tag, input logic [7:0] y, input logic z, input logic c);
    check({tag, "_ov"}, ov4, 1'b1);
    check({tag, "_y"}, y4, y);
    check({tag, "_zero"}, z4, z);
    check({tag, "_carry"}, c4, c);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    logic [63:0] ey;
    logic        ec;
    logic        got;
    ey = ref_y(8, 64'(a), 64'(b), s);
    ec = ref_c(8, 64'(a), 64'(b), s);
    @(negedge clk);
    iv8 = 1'b1; a8 = a; b8 = b; s8 = s;
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      or8 = 1'($urandom_range(0, 1));
      if (ov8) got = 1'b1;
      else @(negedge clk);
    end
    check("w8_result_arrives", got, 1'b1);
    if (got) begin
      check("w8_y", y8, ey);
      check("w8_zero", z8, ey == 64'd0);
      check("w8_carry", c8, ec);
    end
    for (int c = 0; c < 30 && ov8; c++) begin
      or8 = (c >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("w8_drained", ov8, 1'b0);
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
    logic [63:0] ey;
    logic        ec;
    logic        got;
    ey = ref_y(2, 64'(a), 64'(b), s);
    ec = ref_c(2, 64'(a), 64'(b), s);
    @(negedge clk);
    iv2 = 1'b1; a2 = a; b2 = b; s2 = s;
    @(negedge clk);
    iv2 = 1'b0; a2 = ~a; b2 = ~b;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      or2 = 1'($urandom_range(0, 1));
      if (ov2) got = 1'b1;
      else @(negedge clk);
    end
    check("w2_result_arrives", got, 1'b1);
    if (got) begin
      check("w2_y", y2, ey);
      check("w2_zero", z2, ey == 64'd0);
      check("w2_carry", c2, ec);
    end
    for (int c = 0; c < 30 && ov2; c++) begin
      or2 = (c >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("w2_drained", ov2, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; s4 = '0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; s8 = '0;
    iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; s2 = '0;

    repeat (2) @(negedge clk);
    check("rst_y", y4, 8'h00);
    check("rst_zero", z4, 1'b0);
    check("rst_carry", c4, 1'b0);
    check("rst_out_valid", ov4, 1'b0);
    check("rst_in_ready", ir4, 1'b1);
    rst_n = 1'b1;

    issue4(4'b0101, 4'h0, 2'b00);
    expect4("not", 8'h5A, 1'b0, 1'b0);
    check("not_in_ready_low", ir4, 1'b0);
    @(negedge clk);
    check("not_ov_one_cycle", ov4, 1'b0);
    check("not_in_ready_back", ir4, 1'b1);

    issue4(4'hC, 4'hA, 2'b01);
    expect4("nand", 8'h07, 1'b0, 1'b0);
    @(negedge clk);
    issue4(4'hF, 4'hF, 2'b10);
    expect4("add", 8'h1E, 1'b0, 1'b1);
    @(negedge clk);

    issue4(4'hF, 4'hF, 2'b11);
    for (int k = 1; k <= 4; k++) begin
      check("mul_busy_ov", ov4, 1'b0);
      check("mul_busy_in_ready", ir4, 1'b0);
      @(negedge clk);
    end
    expect4("mul_ff", 8'hE1, 1'b0, 1'b0);
    check("mul_done_in_ready", ir4, 1'b0);
    @(negedge clk);
    check("mul_in_ready_back", ir4, 1'b1);

    issue4(4'h7, 4'h0, 2'b11);
    repeat (4) @(negedge clk);
    expect4("mul_zero", 8'h00, 1'b1, 1'b0);
    @(negedge clk);

    or4 = 1'b0;
    issue4(4'h3, 4'h5, 2'b01);
    expect4("bp_first", 8'h0E, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); s4 = 2'b10;
      @(negedge clk);
      check("bp_y_stable", y4, 8'h0E);
      check("bp_in_ready", ir4, 1'b0);
      check("bp_ov_held", ov4, 1'b1);
    end
    iv4 = 1'b0; or4 = 1'b1;
    @(negedge clk);
    check("bp_release_ov", ov4, 1'b0);
    check("bp_release_in_ready", ir4, 1'b1);
    check("bp_no_accept_y", y4, 8'h0E);

    issue4(4'hF, 4'hF, 2'b11);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_y", y4, 8'h00);
    check("arst_ov", ov4, 1'b0);
    check("arst_zero", z4, 1'b0);
    check("arst_carry", c4, 1'b0);
    check("arst_in_ready", ir4, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_abandoned_ov", ov4, 1'b0);
    check("arst_abandoned_y", y4, 8'h00);
    issue4(4'h3, 4'h4, 2'b10);
    expect4("post_rst_add", 8'h07, 1'b0, 1'b0);
    @(negedge clk);

    run8(8'hFF, 8'hFF, 2'b11);
    run8(8'hFF, 8'h01, 2'b10);
    run8(8'hFF, 8'hFF, 2'b01);
    run8(8'h00, 8'hAB, 2'b11);
    for (int i = 0; i < 1000; i++) begin
      run8(8'($urandom), 8'($urandom), 2'($urandom));
    end

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int s = 0; s < 4; s++) begin
          run2(2'(a), 2'(b), 2'(s));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
